// File: rtl/hqm_rcfwl_pgcb_cg_ctrl_pkg.sv
// Shared types and constants for the PGCB clock-gate controller.
// The state encoding is fixed because software and legacy debug views decode it.
package hqm_rcfwl_pgcb_cg_ctrl_pkg;

    typedef enum logic [1:0] {
        ON   = 2'b00,
        HYST = 2'b01,
        OFF  = 2'b10,
        WAKE = 2'b11
    } cg_state_e;

    localparam int SETTLE_W = 3;

endpackage

// File: rtl/hqm_rcfwl_pgcb_ctech_doublesync.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk domain.
// clr_b clears both stages so no stale request survives a reset.
module hqm_rcfwl_pgcb_ctech_doublesync #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clr_b,
    input  logic             clk,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: flops use non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_b) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/hqm_rcfwl_pgcb_cg_ctrl.sv
// Idle-driven clock-gate controller: gates after a hysteresis window, ungates on
// wake/force/activity, and pulses wake_ack once the restored clock has settled.
module hqm_rcfwl_pgcb_cg_ctrl
    import hqm_rcfwl_pgcb_cg_ctrl_pkg::*;
#(
    parameter bit SYNC_WAKE = 1'b1,
    parameter int CNT_W     = 4
) (
    input  logic             pgcb_clk,
    input  logic             pgcb_rst_b,
    input  logic             idle,
    input  logic             wake_async,
    input  logic             force_on,
    input  logic [CNT_W-1:0] cfg_hyst,
    input  logic [2:0]       cfg_settle,
    output logic             clk_en,
    output logic             gated,
    output logic             wake_ack
);

    // One counter serves both hysteresis and settle, so size it for the larger.
    localparam int CW = (CNT_W > SETTLE_W) ? CNT_W : SETTLE_W;

    logic      wake_s;
    logic      keep;
    cg_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic      clk_en_q, gated_q, wake_ack_q;
    logic      wake_ack_d;

    if (SYNC_WAKE) begin : g_sync
        hqm_rcfwl_pgcb_ctech_doublesync u_wake_sync (
            .d     (wake_async),
            .clr_b (pgcb_rst_b),
            .clk   (pgcb_clk),
            .q     (wake_s)
        );
    end else begin : g_nosync
        assign wake_s = wake_async;
    end

    assign keep = wake_s | force_on | ~idle;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wake_ack_d = 1'b0;
        case (state_q)
            ON: begin
                if (!keep) begin
                    state_d = HYST;
                    cnt_d   = CW'(cfg_hyst);
                end
            end
            HYST: begin
                if (keep) begin
                    state_d = ON;
                end else if (cnt_q == '0) begin
                    state_d = OFF;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            OFF: begin
                if (keep) begin
                    state_d = WAKE;
                    cnt_d   = CW'(cfg_settle);
                end
            end
            WAKE: begin
                if (cnt_q == '0) begin
                    state_d    = ON;
                    wake_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ON;
        endcase
    end

    // Outputs are decoded from next-state so they flip on the same edge as the state.
    always_ff @(posedge pgcb_clk) begin
        if (!pgcb_rst_b) begin
            state_q    <= ON;
            cnt_q      <= '0;
            clk_en_q   <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_en_q   <= (state_d != OFF);
            gated_q    <= (state_d == OFF);
            wake_ack_q <= wake_ack_d;
        end
    end

    assign clk_en   = clk_en_q;
    assign gated    = gated_q;
    assign wake_ack = wake_ack_q;

endmodule

// File: tb/tb_hqm_rcfwl_pgcb_cg_ctrl.sv
// Self-checking bench for hqm_rcfwl_pgcb_cg_ctrl: deadline-based reference model
// feeding a per-edge scoreboard, plus directed latency scenarios and random traffic.
module tb_hqm_rcfwl_pgcb_cg_ctrl;

    logic       pgcb_clk = 1'b0;
    logic       pgcb_rst_b;
    logic       idle;
    logic       wake_async;
    logic       force_on;
    logic [3:0] cfg_hyst;
    logic [2:0] cfg_settle;
    logic       clk_en;
    logic       gated;
    logic       wake_ack;

    int checks = 0;
    int errors = 0;

    hqm_rcfwl_pgcb_cg_ctrl #(.SYNC_WAKE(1'b1), .CNT_W(4)) dut (
        .pgcb_clk   (pgcb_clk),
        .pgcb_rst_b (pgcb_rst_b),
        .idle       (idle),
        .wake_async (wake_async),
        .force_on   (force_on),
        .cfg_hyst   (cfg_hyst),
        .cfg_settle (cfg_settle),
        .clk_en     (clk_en),
        .gated      (gated),
        .wake_ack   (wake_ack)
    );

    always #5 pgcb_clk = ~pgcb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks absolute edge deadlines for gating and wake_ack.
    // Expected {clk_en, gated, wake_ack} after each edge goes into exp_q.
    logic [2:0] exp_q[$];
    int  n_edge  = 0;
    int  gate_at = -1;
    int  ack_at  = -1;
    bit  off_m   = 1'b0;
    bit  w1      = 1'b0;
    bit  w2      = 1'b0;

    always @(posedge pgcb_clk) begin
        bit         keep;
        logic [2:0] e;
        n_edge++;
        keep = w2 | force_on | !idle;
        e    = 3'b100;
        if (!pgcb_rst_b) begin
            gate_at = -1;
            ack_at  = -1;
            off_m   = 1'b0;
            w1      = 1'b0;
            w2      = 1'b0;
        end else begin
            w2 = w1;
            w1 = wake_async;
            if (ack_at >= 0) begin
                if (n_edge == ack_at) begin
                    e[0]   = 1'b1;
                    ack_at = -1;
                end
            end else if (off_m) begin
                if (keep) begin
                    off_m  = 1'b0;
                    ack_at = n_edge + int'(cfg_settle) + 1;
                end else begin
                    e = 3'b010;
                end
            end else if (gate_at >= 0) begin
                if (keep) begin
                    gate_at = -1;
                end else if (n_edge == gate_at) begin
                    gate_at = -1;
                    off_m   = 1'b1;
                    e       = 3'b010;
                end
            end else if (!keep) begin
                gate_at = n_edge + int'(cfg_hyst) + 1;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: outputs are presented every edge; compare away from the active edge.
    always @(negedge pgcb_clk) begin
        logic [2:0] e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_outputs", {29'd0, clk_en, gated, wake_ack}, {29'd0, e});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pgcb_clk);
    endtask

    initial begin
        int acks;
        int bad_en;
        int gated_cnt;

        pgcb_rst_b = 1'b0;
        idle       = 1'b0;
        wake_async = 1'b0;
        force_on   = 1'b0;
        cfg_hyst   = 4'd3;
        cfg_settle = 3'd0;
        cyc(2);
        check("reset_clk_en", 32'(clk_en), 32'd1);
        check("reset_gated", 32'(gated), 32'd0);
        check("reset_wake_ack", 32'(wake_ack), 32'd0);

        // Gating with cfg_hyst=3: gate exactly at edge 5 after release.
        pgcb_rst_b = 1'b1;
        idle       = 1'b1;
        cyc(4);
        check("gate_edge4_clk_en", 32'(clk_en), 32'd1);
        cyc(1);
        check("gate_edge5_clk_en", 32'(clk_en), 32'd0);
        check("gate_edge5_gated", 32'(gated), 32'd1);

        // Async wake through the synchronizer, cfg_settle=2.
        cfg_settle = 3'd2;
        wake_async = 1'b1;
        cyc(2);
        check("wake_k1_clk_en", 32'(clk_en), 32'd0);
        cyc(1);
        check("wake_k2_clk_en", 32'(clk_en), 32'd1);
        check("wake_k2_gated", 32'(gated), 32'd0);
        cyc(2);
        check("wake_k4_ack", 32'(wake_ack), 32'd0);
        cyc(1);
        check("wake_k5_ack", 32'(wake_ack), 32'd1);
        wake_async = 1'b0;
        cyc(1);
        check("wake_k6_ack", 32'(wake_ack), 32'd0);

        // Hysteresis abort: idle drops before the count expires.
        idle     = 1'b0;
        cfg_hyst = 4'd5;
        cyc(4);
        idle = 1'b1;
        cyc(2);
        idle      = 1'b0;
        bad_en    = 0;
        gated_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (!clk_en) bad_en++;
            if (gated) gated_cnt++;
        end
        check("abort_clk_en_low_cycles", 32'(bad_en), 32'd0);
        check("abort_gated_cycles", 32'(gated_cnt), 32'd0);

        // Boundary: zero hysteresis and zero settle.
        cfg_hyst   = 4'd0;
        cfg_settle = 3'd0;
        idle       = 1'b1;
        cyc(1);
        check("zero_hyst_edge1_gated", 32'(gated), 32'd0);
        cyc(1);
        check("zero_hyst_edge2_gated", 32'(gated), 32'd1);
        force_on = 1'b1;
        cyc(1);
        check("force_clk_en", 32'(clk_en), 32'd1);
        check("force_ack_early", 32'(wake_ack), 32'd0);
        cyc(1);
        check("force_ack", 32'(wake_ack), 32'd1);
        force_on = 1'b0;
        cyc(1);
        check("force_ack_width", 32'(wake_ack), 32'd0);
        cyc(1);
        check("regate_gated", 32'(gated), 32'd1);

        // Reset while gated restores the clock on that edge.
        pgcb_rst_b = 1'b0;
        cyc(1);
        check("rst_off_clk_en", 32'(clk_en), 32'd1);
        check("rst_off_gated", 32'(gated), 32'd0);
        check("rst_off_ack", 32'(wake_ack), 32'd0);
        pgcb_rst_b = 1'b1;
        idle       = 1'b0;
        cyc(3);
        check("rst_off_stays_on", {30'd0, clk_en, gated}, 32'b10);

        // Simultaneous force_on and wake_async: single wake, then re-gate.
        idle       = 1'b1;
        cfg_hyst   = 4'd1;
        cfg_settle = 3'd3;
        cyc(3);
        check("sim_pre_gated", 32'(gated), 32'd1);
        force_on   = 1'b1;
        wake_async = 1'b1;
        cyc(1);
        force_on   = 1'b0;
        wake_async = 1'b0;
        acks       = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (wake_ack) acks++;
        end
        check("sim_single_ack", 32'(acks), 32'd1);
        check("sim_regated", 32'(gated), 32'd1);

        // Random traffic, including mid-count cfg changes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)   idle = ~idle;
            if ($urandom_range(0, 15) == 0)  wake_async = ~wake_async;
            if ($urandom_range(0, 31) == 0)  force_on = ~force_on;
            cfg_hyst   = 4'($urandom_range(0, 15));
            cfg_settle = 3'($urandom_range(0, 7));
            pgcb_rst_b = ($urandom_range(0, 199) != 0);
            cyc(1);
        end

        cyc(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
